fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_slot.sv | 34 +++
 rtl/fetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, constants and FSM state type for the instruction fetch sequencer.
package fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_BYTES = 64'd4;
    localparam logic [XLEN-1:0] ALIGN_MASK  = ~64'd3;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        FAULT
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_slot.sv
// Decode slot register: holds one fetched instruction and its PC until decode consumes it.
module fetch_slot
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            load,
    input  logic [ILEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    input  logic            consume,
    output logic            valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    // Flush beats a refill, and a refill beats a plain consume so back-to-back delivery keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding request, decode slot plus a one-entry hold buffer.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets in the FAULT state.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instrD_valid,
    output logic [ILEN-1:0] instructionD,
    output logic [XLEN-1:0] pcD,
    input  logic            dec_ready,
    output logic            fetch_fault
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] hold_q, hold_d;
    logic [XLEN-1:0] redirect_target;
    logic [ILEN-1:0] slot_instr;
    logic            slot_free;
    logic            slot_load;
    logic            outstanding;
    logic            target_bad;
    logic            pc_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc;
    assign target_bad      = is_misaligned(redirect_pc[1:0]);
    assign pc_bad          = is_misaligned(pc_q[1:0]);
    assign fetch_fault     = (state_q == FAULT);
`else
    assign redirect_target = redirect_pc & ALIGN_MASK;
    assign target_bad      = 1'b0;
    assign pc_bad          = 1'b0;
    assign fetch_fault     = 1'b0;
`endif

    assign imem_req_addr = pc_q;
    assign slot_free     = !instrD_valid || dec_ready;

    // A response is still owed to us if the memory just took a request or we are waiting on one.
    // DRAIN counts too, so a redirect coinciding with the stale response does not strand the FSM.
    assign outstanding = ((state_q == WAIT)  && !imem_rsp_valid) ||
                         ((state_q == REQ)   &&  imem_req_ready) ||
                         ((state_q == DRAIN) && !imem_rsp_valid);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_d         = hold_q;
        slot_load      = 1'b0;
        slot_instr     = hold_q;
        imem_req_valid = (state_q == REQ);

        if (redirect_valid) begin
            pc_d = redirect_target;
            if (outstanding) begin
                state_d = DRAIN;
            end else if (target_bad) begin
                state_d = FAULT;
            end else begin
                state_d = REQ;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = REQ;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (slot_free) begin
                            slot_load  = 1'b1;
                            slot_instr = imem_rsp_data;
                            pc_d       = pc_q + INSTR_BYTES;
                            state_d    = REQ;
                        end else begin
                            hold_d  = imem_rsp_data;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        slot_load = 1'b1;
                        pc_d      = pc_q + INSTR_BYTES;
                        state_d   = REQ;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        state_d = pc_bad ? FAULT : REQ;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    fetch_slot u_slot (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .load       (slot_load),
        .load_instr (slot_instr),
        .load_pc    (pc_q),
        .consume    (instrD_valid && dec_ready),
        .valid      (instrD_valid),
        .instr      (instructionD),
        .pc         (pcD)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a single-outstanding memory model returning addr[31:0] as data.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instrD_valid;
    logic [31:0] instructionD;
    logic [63:0] pcD;
    logic        dec_ready;
    logic        fetch_fault;

    int          compared   = 0;
    int          mismatched = 0;
    int          rsp_delay  = 0;
    int          wait_cnt   = 0;
    int          req_count  = 0;
    logic        pend       = 1'b0;
    logic [31:0] paddr      = 32'h0;
    logic [63:0] exp_pc;

    fetch_sequencer #(.RESET_PC(64'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instrD_valid   (instrD_valid),
        .instructionD   (instructionD),
        .pcD            (pcD),
        .dec_ready      (dec_ready),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory: answers each accepted request after rsp_delay extra cycles, reset along with the DUT.
    always @(posedge clk) begin
        if (rst) begin
            pend           <= 1'b0;
            imem_rsp_valid <= 1'b0;
            wait_cnt       <= 0;
            req_count      <= 0;
        end else if (imem_req_valid && imem_req_ready) begin
            req_count <= req_count + 1;
            if (rsp_delay == 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= imem_req_addr[31:0];
                pend           <= 1'b0;
            end else begin
                imem_rsp_valid <= 1'b0;
                pend           <= 1'b1;
                paddr          <= imem_req_addr[31:0];
                wait_cnt       <= rsp_delay - 1;
            end
        end else if (pend) begin
            if (wait_cnt == 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= paddr;
                pend           <= 1'b0;
            end else begin
                imem_rsp_valid <= 1'b0;
                wait_cnt       <= wait_cnt - 1;
            end
        end else begin
            imem_rsp_valid <= 1'b0;
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic dr,
                                 input logic rv, input logic [63:0] rpc);
        rst            = r;
        imem_req_ready = rdy;
        dec_ready      = dr;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        tick(3);
        checkOutput("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        checkOutput("rst_instr_valid", {63'h0, instrD_valid}, 64'h0);
        checkOutput("rst_instructionD", {32'h0, instructionD}, 64'h13);
        checkOutput("rst_pcD", pcD, 64'h0);
        checkOutput("rst_fault", {63'h0, fetch_fault}, 64'h0);
        checkOutput("rst_addr", imem_req_addr, 64'h8000_0000);

        $display("[TB] stream from reset PC");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        checkOutput("idle_req_valid", {63'h0, imem_req_valid}, 64'h0);
        tick(1);
        checkOutput("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
        checkOutput("first_req_addr", imem_req_addr, 64'h8000_0000);
        tick(1);
        checkOutput("wait_req_valid", {63'h0, imem_req_valid}, 64'h0);
        tick(1);
        checkOutput("first_valid", {63'h0, instrD_valid}, 64'h1);
        checkOutput("first_pcD", pcD, 64'h8000_0000);
        checkOutput("first_instr", {32'h0, instructionD}, 64'h8000_0000);
        checkOutput("second_addr", imem_req_addr, 64'h8000_0004);
        tick(1);
        checkOutput("consumed_valid", {63'h0, instrD_valid}, 64'h0);
        tick(1);
        checkOutput("second_valid", {63'h0, instrD_valid}, 64'h1);
        checkOutput("second_pcD", pcD, 64'h8000_0004);
        exp_pc = 64'h8000_0008;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (i % 2 == 1) begin
                checkOutput("stream_valid", {63'h0, instrD_valid}, 64'h1);
                checkOutput("stream_pcD", pcD, exp_pc);
                exp_pc = exp_pc + 64'd4;
            end else begin
                checkOutput("stream_gap", {63'h0, instrD_valid}, 64'h0);
            end
        end

        $display("[TB] decode stall");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        tick(2);
        checkOutput("hold_req_valid", {63'h0, imem_req_valid}, 64'h0);
        tick(3);
        checkOutput("stall_valid", {63'h0, instrD_valid}, 64'h1);
        checkOutput("stall_pcD", pcD, 64'h8000_0010);
        checkOutput("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
        checkOutput("stall_req_count", 64'(req_count), 64'd6);
        tick(1);
        checkOutput("stall_last_pcD", pcD, 64'h8000_0010);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        tick(1);
        checkOutput("release_valid", {63'h0, instrD_valid}, 64'h1);
        checkOutput("release_pcD", pcD, 64'h8000_0014);
        checkOutput("release_instr", {32'h0, instructionD}, 64'h8000_0014);
        checkOutput("release_addr", imem_req_addr, 64'h8000_0018);
        tick(2);
        checkOutput("after_hold_pcD", pcD, 64'h8000_0018);
        rsp_delay = 2;

        $display("[TB] redirect while response pending");
        tick(1);
        checkOutput("pending_req_valid", {63'h0, imem_req_valid}, 64'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 64'h1000);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        rsp_delay = 0;
        checkOutput("drain_valid", {63'h0, instrD_valid}, 64'h0);
        checkOutput("drain_req_valid", {63'h0, imem_req_valid}, 64'h0);
        tick(1);
        checkOutput("drain_stale_valid", {63'h0, instrD_valid}, 64'h0);
        tick(1);
        checkOutput("redir_req_valid", {63'h0, imem_req_valid}, 64'h1);
        checkOutput("redir_req_addr", imem_req_addr, 64'h1000);
        checkOutput("redir_slot_empty", {63'h0, instrD_valid}, 64'h0);
        tick(1);
        checkOutput("redir_wait_empty", {63'h0, instrD_valid}, 64'h0);
        tick(1);
        checkOutput("redir_valid", {63'h0, instrD_valid}, 64'h1);
        checkOutput("redir_pcD", pcD, 64'h1000);
        checkOutput("redir_instr", {32'h0, instructionD}, 64'h1000);

        $display("[TB] redirect on request handshake");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 64'h3000);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        checkOutput("hs_drain_req_valid", {63'h0, imem_req_valid}, 64'h0);
        checkOutput("hs_drain_valid", {63'h0, instrD_valid}, 64'h0);
        tick(1);
        checkOutput("hs_req_valid", {63'h0, imem_req_valid}, 64'h1);
        checkOutput("hs_req_addr", imem_req_addr, 64'h3000);
        tick(2);
        checkOutput("hs_valid", {63'h0, instrD_valid}, 64'h1);
        checkOutput("hs_pcD", pcD, 64'h3000);
        checkOutput("hs_instr", {32'h0, instructionD}, 64'h3000);

        $display("[TB] misaligned redirect");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 64'h1002);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        checkOutput("mis_valid", {63'h0, instrD_valid}, 64'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("mis_fault", {63'h0, fetch_fault}, 64'h1);
        checkOutput("mis_req_valid", {63'h0, imem_req_valid}, 64'h0);
        checkOutput("mis_addr", imem_req_addr, 64'h1002);
`else
        checkOutput("mis_fault", {63'h0, fetch_fault}, 64'h0);
        checkOutput("mis_req_valid", {63'h0, imem_req_valid}, 64'h1);
        checkOutput("mis_addr", imem_req_addr, 64'h1000);
`endif
        tick(1);
        checkOutput("mis_idle_req_valid", {63'h0, imem_req_valid}, 64'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("mis_fault_held", {63'h0, fetch_fault}, 64'h1);
`else
        checkOutput("mis_fault_held", {63'h0, fetch_fault}, 64'h0);
`endif
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 64'h2000);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        checkOutput("resume_fault", {63'h0, fetch_fault}, 64'h0);
        checkOutput("resume_req_valid", {63'h0, imem_req_valid}, 64'h1);
        checkOutput("resume_addr", imem_req_addr, 64'h2000);
        checkOutput("resume_empty", {63'h0, instrD_valid}, 64'h0);
        tick(2);
        checkOutput("resume_pcD", pcD, 64'h2000);

        $display("[TB] PC wraparound");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        tick(1);
        checkOutput("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(2);
        checkOutput("wrap_pcD", pcD, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("wrap_instr", {32'h0, instructionD}, 64'hFFFF_FFFC);
        checkOutput("wrap_next_addr", imem_req_addr, 64'h0);
        checkOutput("wrap_next_valid", {63'h0, imem_req_valid}, 64'h1);

        $display("[TB] reset mid-transaction");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        tick(1);
        checkOutput("rst2_req_valid", {63'h0, imem_req_valid}, 64'h0);
        checkOutput("rst2_valid", {63'h0, instrD_valid}, 64'h0);
        checkOutput("rst2_addr", imem_req_addr, 64'h8000_0000);
        checkOutput("rst2_instr", {32'h0, instructionD}, 64'h13);
        checkOutput("rst2_pcD", pcD, 64'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        tick(1);
        checkOutput("rst2_first_addr", imem_req_addr, 64'h8000_0000);
        tick(2);
        checkOutput("rst2_first_valid", {63'h0, instrD_valid}, 64'h1);
        checkOutput("rst2_first_pcD", pcD, 64'h8000_0000);
        checkOutput("rst2_first_instr", {32'h0, instructionD}, 64'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
